// File: rtl/pamac_seq_cp.sv
// -----------------------------------------------------------------------------
// pamac_seq_cp
// Sequential control path for the PAMAC multiplier. On start it latches the
// operand select, the chosen radix-4 Booth group register and the zero-skip
// mode. It then issues one {group_idx, double, neg} term per accepted
// handshake, lowest group first, optionally skipping null groups.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a decomposition (IDLE only)
//   ETC_A, ETC_W_in            effective term counts of activation / weight
//   BPR_A, BPR_W               Booth groups, group i = bits [3i+2:3i]
//   MDecomp, AWDecomp          compare-based or forced operand select
//   zero_skip_en               skip null groups for this decomposition
//   term_ready                 datapath accepts the presented term
//   busy                       high in RUN and DONE
//   mul_sel                    latched select, 1 = W decomposed
//   term_valid, group_idx      presented term and its group index
//   double, neg, term_zero     Booth decode of the presented group
//   last                       presented term is the final one
//   done                       one-cycle completion pulse
//   term_count                 terms accepted since the last start
// -----------------------------------------------------------------------------
module pamac_seq_cp #(
    parameter int NUM_GROUPS = 8,
    parameter int ETC_W      = 4,
    parameter int IDX_W      = $clog2(NUM_GROUPS),
    parameter int CNT_W      = $clog2(NUM_GROUPS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ETC_W-1:0]        ETC_A,
    input  logic [ETC_W-1:0]        ETC_W_in,
    input  logic [3*NUM_GROUPS-1:0] BPR_A,
    input  logic [3*NUM_GROUPS-1:0] BPR_W,
    input  logic                    MDecomp,
    input  logic                    AWDecomp,
    input  logic                    zero_skip_en,
    input  logic                    term_ready,
    output logic                    busy,
    output logic                    mul_sel,
    output logic                    term_valid,
    output logic [IDX_W-1:0]        group_idx,
    output logic                    double,
    output logic                    neg,
    output logic                    term_zero,
    output logic                    last,
    output logic                    done,
    output logic [CNT_W-1:0]        term_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Radix-4 Booth decode helpers
    function automatic logic booth_double(input logic [2:0] g);
        case (g)
            3'b011, 3'b100: booth_double = 1'b1;
            default:        booth_double = 1'b0;
        endcase
    endfunction

    function automatic logic booth_neg(input logic [2:0] g);
        case (g)
            3'b100, 3'b101, 3'b110: booth_neg = 1'b1;
            default:                booth_neg = 1'b0;
        endcase
    endfunction

    function automatic logic booth_zero(input logic [2:0] g);
        case (g)
            3'b000, 3'b111: booth_zero = 1'b1;
            default:        booth_zero = 1'b0;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sel_q, sel_d;
    logic [3*NUM_GROUPS-1:0] bpr_q, bpr_d;
    logic                    skip_q, skip_d;

    logic                    valid_q, last_q, dbl_q, neg_q, zero_q, done_q, busy_q;
    logic [IDX_W-1:0]        idx_q;

    logic                    found_s, more_s, hit_s;
    logic [IDX_W-1:0]        idx_s;
    logic [2:0]              grp_s, grp_hit_s;
    logic                    present_s;

    // Next-state logic: latch on start, advance the pointer on each handshake
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        bpr_d   = bpr_q;
        skip_d  = skip_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = MDecomp ? (ETC_A > ETC_W_in) : AWDecomp;
                    bpr_d   = sel_d ? BPR_W : BPR_A;
                    skip_d  = zero_skip_en;
                    ptr_d   = {CNT_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_q) begin
                    if (term_ready) begin
                        ptr_d   = CNT_W'(idx_q) + CNT_W'(1'b1);
                        cnt_d   = cnt_q + CNT_W'(1'b1);
                        state_d = last_q ? ST_DONE : ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    // nothing eligible at the pointer: all-null operand
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Priority search over the next-cycle view, so term outputs can be registered
    always_comb begin
        found_s   = 1'b0;
        more_s    = 1'b0;
        idx_s     = {IDX_W{1'b0}};
        grp_hit_s = 3'b000;
        grp_s     = 3'b000;
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            grp_s     = bpr_d[3*i +: 3];
            hit_s     = (!skip_d || !booth_zero(grp_s)) && (CNT_W'(i) >= ptr_d);
            more_s    = more_s | (hit_s & found_s);
            idx_s     = (hit_s & ~found_s) ? IDX_W'(i) : idx_s;
            grp_hit_s = (hit_s & ~found_s) ? grp_s : grp_hit_s;
            found_s   = found_s | hit_s;
        end
        present_s = (state_d == ST_RUN) && found_s;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= {CNT_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            sel_q   <= 1'b0;
            bpr_q   <= {(3*NUM_GROUPS){1'b0}};
            skip_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            dbl_q   <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            bpr_q   <= bpr_d;
            skip_q  <= skip_d;
            valid_q <= present_s;
            idx_q   <= present_s ? idx_s : {IDX_W{1'b0}};
            dbl_q   <= present_s & booth_double(grp_hit_s);
            neg_q   <= present_s & booth_neg(grp_hit_s);
            zero_q  <= present_s & booth_zero(grp_hit_s);
            last_q  <= present_s & ~more_s;
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign busy       = busy_q;
    assign mul_sel    = sel_q;
    assign term_valid = valid_q;
    assign group_idx  = idx_q;
    assign double     = dbl_q;
    assign neg        = neg_q;
    assign term_zero  = zero_q;
    assign last       = last_q;
    assign done       = done_q;
    assign term_count = cnt_q;

endmodule

// File: doc/pamac_seq_cp.md
# pamac_seq_cp

Sequential, parametrised control path for the PAMAC multiplier in the FoFIR PE. On `start` it latches the decomposition choice and the chosen operand's radix-4 Booth group register (BPR). It then walks the groups itself and issues one {index, double, neg} term per accepted handshake to the PAMAC datapath. With zero-skip enabled, null groups are skipped, so latency tracks the operand's essential terms rather than its width.

## Interface
- `NUM_GROUPS`, default 8: Booth groups per operand, each 3 bits; must be ≥2.
- `ETC_W`, default 4: width of the effective-term-count inputs.
- `IDX_W`, default $clog2(NUM_GROUPS): width of the group index.
- `CNT_W`, default $clog2(NUM_GROUPS+1): width of the term counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a decomposition; sampled only in IDLE.
- `ETC_A`, `ETC_W_in`  in  ETC_W each  effective term counts of activation and weight.
- `BPR_A`, `BPR_W`  in  3*NUM_GROUPS each  Booth groups; group i is bits [3i+2:3i].
- `MDecomp`  in  1  1 = pick the operand by ETC compare; 0 = use `AWDecomp`.
- `AWDecomp`  in  1  forced operand select when `MDecomp`=0.
- `zero_skip_en`  in  1  1 = skip null groups; sampled at `start`.
- `term_ready`  in  1  datapath accepts the current term.
- `busy`  out  1  high in RUN and DONE.
- `mul_sel`  out  1  latched operand select; 1 = W decomposed, 0 = A.
- `term_valid`  out  1  a term is presented.
- `group_idx`  out  IDX_W  index of the presented group (datapath shifts by 2*idx).
- `double`, `neg`, `term_zero`  out  1 each  Booth decode of the presented group.
- `last`  out  1  the presented term is the final one.
- `done`  out  1  one-cycle completion pulse.
- `term_count`  out  CNT_W  terms accepted since the last `start`.

## Operation
- Booth decode of group g:
  - double = (g==011 or 100).
  - neg = (g==100, 101 or 110).
  - term_zero = (g==000 or 111).
- Select at `start`: `mul_sel` = `MDecomp` ? (ETC_A > ETC_W_in) : `AWDecomp`. Then BPR = `mul_sel` ? `BPR_W` : `BPR_A`. The select, BPR and `zero_skip_en` are latched and held until the next `start`; later input changes have no effect.
- Group eligibility: with skip enabled, a group is eligible when it is not term_zero. With skip disabled, every group is eligible.
- State machine: IDLE, RUN, DONE.
  - IDLE + `start`: latch, ptr←0, `term_count`←0, go to RUN.
  - RUN: a priority search finds the lowest eligible group ≥ ptr.
    - If one is found: `term_valid`=1, with `group_idx`, `double`, `neg`, `term_zero` taken from that group.
    - `last`=1 when no other eligible group exists above it.
    - On `term_valid`&`term_ready`: ptr←idx+1, `term_count`+1. If `last` was 1, go to DONE.
    - If no eligible group exists at ptr (an all-null operand under skip): go to DONE with `term_valid`=0.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Presented term outputs are stable while `term_valid`=1 and `term_ready`=0.
- `start` during RUN or DONE is ignored.
- Skip disabled: exactly NUM_GROUPS terms are issued in order 0..NUM_GROUPS-1, null groups included with `term_zero`=1.
- Outputs when `term_valid`=0: `double`, `neg`, `term_zero`, `last` and `group_idx` are driven 0.

## Timing
- Reset (async assert, sync release) clears all state:
  - state = IDLE, ptr = 0;
  - `busy`, `term_valid`, `done`, `last`, `double`, `neg`, `term_zero` = 0;
  - `group_idx` = 0, `term_count` = 0, `mul_sel` = 0.
- Reset mid-operation aborts immediately; no `done` is produced.
- Term timing: `start` sampled at edge T gives the first `term_valid` in cycle T+1.
- With `term_ready` held high and N≥1 eligible terms:
  - terms are presented in cycles T+1..T+N;
  - `done` is in cycle T+N+1;
  - IDLE is reached, and a new `start` is accepted, in cycle T+N+2.
- All-null operand with skip enabled: RUN in cycle T+1 with no term, `done` in cycle T+2.
- `term_count` updates on the handshake edge. It holds its final value through DONE and IDLE until the next `start`.
- Each cycle with `term_ready` low extends the sequence by one cycle.

## Test plan
- **Compare-selected operand, skip on.** MDecomp=1, ETC_A=2, ETC_W_in=5, BPR_A group0=011, group2=101, all other groups 000; ready high.
  - Required: `mul_sel`=0.
  - Term idx0 with double=1, neg=0; term idx2 with double=0, neg=1, last=1.
  - `done` at T+3; `term_count`=2.
- **Compare selects W.** ETC_A=6, ETC_W_in=1, `BPR_W` group7=100.
  - Required: `mul_sel`=1; a single term idx7 with double=1, neg=1, last=1.
- **Forced select, skip off.** MDecomp=0, AWDecomp=0, `BPR_A` all 000.
  - Required: 8 terms idx0..7, all with `term_zero`=1; `last` only on idx7; `term_count`=8.
- **Backpressure.** Same stimulus as the first scenario; `term_ready` low for 3 cycles on the idx2 term.
  - Required: idx2 and its decode held stable for those cycles; `done` at T+6.
- **Boundaries.**
  - `BPR_A` groups all 111 with skip on: no `term_valid`, `done` at T+2, `term_count`=0.
  - `start` pulsed mid-RUN: ignored.
  - Inputs changed mid-RUN: latched values unaffected.
- **Reset mid-operation.** Drop `rst_n` low after the first term.
  - Required: all outputs go to reset values immediately, and no `done` is produced.
  - A `start` after release runs normally from idx0.
